edge_relax_unit: RTL and testbench

EDGE_RELAX_UNIT -- requirements
Module: edge_relax_unit

---
 rtl/edge_relax_unit.sv | 114 +++++++++++
 tb/tb_edge_relax_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/edge_relax_unit.sv
// edge_relax_unit: relaxes every outgoing edge of one popped vertex and pushes improved neighbours to the queue.
module edge_relax_unit #(
  parameter int          QUEUE_DEPTH = 64,
  parameter logic [15:0] DIST_INF    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pop_vertex,
  input  logic [15:0] pop_dist,
  output logic [15:0] dist_addr,
  input  logic [15:0] dist_rdata,
  output logic        dist_we,
  output logic [15:0] dist_wdata,
  output logic [15:0] prev_wdata,
  output logic [15:0] adj_addr,
  input  logic [31:0] adj_rdata,
  input  logic [15:0] queue_length,
  output logic [15:0] in_vertex,
  output logic [15:0] in_prev_vertex,
  output logic [15:0] dist_from_prev,
  output logic        opcode,
  output logic        op_en,
  output logic        busy,
  output logic        done,
  output logic        stale,
  output logic        overflow
);
  typedef enum logic [3:0] {
    IDLE, RD_DIST, CHK_DIST, RD_ROW, GET_ROW, EDGE_RD, NBR_RD, EVAL, PUSH, PUSH_WAIT, FIN
  } state_t;
  localparam logic [15:0] QD = 16'(QUEUE_DEPTH);
  state_t state, next, adv;
  logic ph, ph_n, stale_q, ovf_q, room, push, improve, is_stale, step;
  logic [15:0] vtx, pd, first, cnt, idx, nbr, wt, cand, idx_inc;
  logic [16:0] sum;
  assign sum      = {1'b0, pd} + {1'b0, wt};
  assign cand     = (sum[16] || sum[15:0] == DIST_INF) ? DIST_INF : sum[15:0];
  assign room     = queue_length < QD;
  assign improve  = cand < dist_rdata;
  assign is_stale = pd > dist_rdata;
  assign idx_inc  = idx + 16'd1;
  assign adv      = (idx_inc < cnt) ? EDGE_RD : FIN;
  assign step     = (state == EVAL && !improve) || (state == PUSH && !room) || (state == PUSH_WAIT && ph);
  // ph is a second-cycle marker for the two-cycle states and the stale path's extra FIN cycle
  always_comb begin
    next = state;
    ph_n = 1'b0;
    case (state)
      IDLE:      next = start ? RD_DIST : IDLE;
      RD_DIST:   next = CHK_DIST;
      CHK_DIST:  begin next = is_stale ? FIN : RD_ROW; ph_n = is_stale; end
      RD_ROW:    next = GET_ROW;
      GET_ROW:   next = (adj_rdata[15:0] == 16'd0) ? FIN : EDGE_RD;
      EDGE_RD:   next = NBR_RD;
      NBR_RD:    begin next = ph ? EVAL : NBR_RD; ph_n = !ph; end
      EVAL:      next = improve ? PUSH : adv;
      PUSH:      next = room ? PUSH_WAIT : adv;
      PUSH_WAIT: begin next = ph ? adv : PUSH_WAIT; ph_n = !ph; end
      FIN:       next = ph ? FIN : IDLE;
      default:   next = IDLE;
    endcase
  end
  assign push           = !reset && state == PUSH && room;
  assign dist_we        = push;
  assign op_en          = push;
  assign opcode         = push;
  assign dist_wdata     = push ? cand : 16'd0;
  assign prev_wdata     = push ? vtx : 16'd0;
  assign in_vertex      = push ? nbr : 16'd0;
  assign in_prev_vertex = push ? vtx : 16'd0;
  assign dist_from_prev = push ? cand : 16'd0;
  assign dist_addr      = reset ? 16'd0 : state == RD_DIST ? vtx : ((state == NBR_RD && ph) || push) ? nbr : 16'd0;
  assign adj_addr       = reset ? 16'd0 : state == RD_ROW ? vtx : state == EDGE_RD ? first + idx : 16'd0;
  assign busy           = !reset && state != IDLE;
  assign done           = !reset && state == FIN && !ph;
  assign stale          = !reset && stale_q;
  assign overflow       = !reset && ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ph      <= 1'b0;
      vtx     <= '0;
      pd      <= '0;
      first   <= '0;
      cnt     <= '0;
      idx     <= '0;
      nbr     <= '0;
      wt      <= '0;
      stale_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= next;
      ph    <= ph_n;
      if (state == IDLE && start) begin
        vtx     <= pop_vertex;
        pd      <= pop_dist;
        stale_q <= 1'b0;
      end
      if (state == GET_ROW) begin
        first <= adj_rdata[31:16];
        cnt   <= adj_rdata[15:0];
        idx   <= 16'd0;
      end
      if (state == NBR_RD && !ph) begin
        nbr <= adj_rdata[31:16];
        wt  <= adj_rdata[15:0];
      end
      if (step) idx <= idx_inc;
      if (state == PUSH && !room) ovf_q <= 1'b1;
      if (state == FIN && ph) stale_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_edge_relax_unit.sv
// tb_edge_relax_unit: directed table of popped vertices against RAM models, plus reset and busy-start sequences.
module tb_edge_relax_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] pop_vertex = '0, pop_dist = '0, queue_length = '0;
  logic [15:0] dist_addr, dist_rdata, dist_wdata, prev_wdata, adj_addr;
  logic [15:0] in_vertex, in_prev_vertex, dist_from_prev;
  logic [31:0] adj_rdata;
  logic dist_we, opcode, op_en, busy, done, stale, overflow;
  logic [15:0] dist_mem [0:65535];
  logic [31:0] adj_mem [0:65535];
  logic [48:0] pq [$];
  int nwr = 0, errs = 0, checks = 0;

  edge_relax_unit dut (
    .clk(clk), .reset(reset), .start(start), .pop_vertex(pop_vertex), .pop_dist(pop_dist),
    .dist_addr(dist_addr), .dist_rdata(dist_rdata), .dist_we(dist_we), .dist_wdata(dist_wdata),
    .prev_wdata(prev_wdata), .adj_addr(adj_addr), .adj_rdata(adj_rdata), .queue_length(queue_length),
    .in_vertex(in_vertex), .in_prev_vertex(in_prev_vertex), .dist_from_prev(dist_from_prev),
    .opcode(opcode), .op_en(op_en), .busy(busy), .done(done), .stale(stale), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dist_rdata <= dist_mem[dist_addr];
    adj_rdata  <= adj_mem[adj_addr];
    if (dist_we) begin
      dist_mem[dist_addr] <= dist_wdata;
      nwr <= nwr + 1;
    end
    if (op_en) pq.push_back({opcode, in_vertex, in_prev_vertex, dist_from_prev});
  end

  typedef struct {
    logic [15:0] v, pd, ql;
    int dc, np;
    logic st, ov, dbl;
    logic [48:0] fp, lp;
  } rec_t;
  rec_t tbl [6];

  task automatic check(input string name, input logic [48:0] act, input logic [48:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input rec_t r);
    int cyc, b, w;
    b = pq.size();
    w = nwr;
    pop_vertex = r.v;
    pop_dist = r.pd;
    queue_length = r.ql;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (r.dbl && cyc == 2) begin
        start = 1'b1;
        pop_vertex = 16'd3;
        pop_dist = 16'd9;
      end
    end while (!done && cyc < 200);
    check($sformatf("v%0d done_cycle", r.v), 49'(cyc), 49'(r.dc));
    check($sformatf("v%0d stale", r.v), 49'(stale), 49'(r.st));
    check($sformatf("v%0d overflow", r.v), 49'(overflow), 49'(r.ov));
    check($sformatf("v%0d pushes", r.v), 49'(pq.size() - b), 49'(r.np));
    check($sformatf("v%0d writes", r.v), 49'(nwr - w), 49'(r.np));
    if (r.np > 0 && pq.size() > b) begin
      check($sformatf("v%0d first_push", r.v), pq[b], r.fp);
      check($sformatf("v%0d last_push", r.v), pq[pq.size() - 1], r.lp);
    end
    @(negedge clk);
    check($sformatf("v%0d busy_after", r.v), 49'(busy), 49'(0));
  endtask

  initial begin
    int cyc;
    rec_t r;
    for (int i = 0; i < 65536; i++) begin
      dist_mem[i] <= 16'hFFFF;
      adj_mem[i] = 32'h0;
    end
    @(negedge clk);
    dist_mem[0] <= 16'd0;
    adj_mem[0] = {16'h0100, 16'd2};
    adj_mem[16'h0100] = {16'd1, 16'd4};
    adj_mem[16'h0101] = {16'd2, 16'd7};
    dist_mem[3] <= 16'd5;
    dist_mem[4] <= 16'hFFF0;
    adj_mem[4] = {16'h0200, 16'd1};
    adj_mem[16'h0200] = {16'd5, 16'h0020};
    dist_mem[6] <= 16'd10;
    adj_mem[6] = {16'h0300, 16'd1};
    adj_mem[16'h0300] = {16'd7, 16'd3};
    dist_mem[8] <= 16'd0;
    dist_mem[11] <= 16'd2;
    adj_mem[11] = {16'h0500, 16'd3};
    adj_mem[16'h0500] = {16'd12, 16'd1};
    adj_mem[16'h0501] = {16'd13, 16'd5};
    adj_mem[16'h0502] = {16'd14, 16'd4};
    dist_mem[12] <= 16'd1;
    dist_mem[13] <= 16'd7;
    dist_mem[14] <= 16'd7;
    dist_mem[15] <= 16'd0;
    adj_mem[15] = {16'h0400, 16'd1};
    adj_mem[16'h0400] = {16'd16, 16'd1};
    tbl[0] = '{v:16'd0,  pd:16'd0,     ql:16'd0,  dc:19, np:2, st:1'b0, ov:1'b0, dbl:1'b0,
               fp:{1'b1, 16'd1, 16'd0, 16'd4}, lp:{1'b1, 16'd2, 16'd0, 16'd7}};
    tbl[1] = '{v:16'd3,  pd:16'd9,     ql:16'd0,  dc:4,  np:0, st:1'b1, ov:1'b0, dbl:1'b0, fp:'0, lp:'0};
    tbl[2] = '{v:16'd4,  pd:16'hFFF0,  ql:16'd0,  dc:9,  np:0, st:1'b0, ov:1'b0, dbl:1'b0, fp:'0, lp:'0};
    tbl[3] = '{v:16'd11, pd:16'd2,     ql:16'd63, dc:20, np:1, st:1'b0, ov:1'b0, dbl:1'b0,
               fp:{1'b1, 16'd14, 16'd11, 16'd6}, lp:{1'b1, 16'd14, 16'd11, 16'd6}};
    tbl[4] = '{v:16'd6,  pd:16'd10,    ql:16'd64, dc:10, np:0, st:1'b0, ov:1'b1, dbl:1'b0, fp:'0, lp:'0};
    tbl[5] = '{v:16'd8,  pd:16'd0,     ql:16'd0,  dc:5,  np:0, st:1'b0, ov:1'b1, dbl:1'b1, fp:'0, lp:'0};
    repeat (3) @(negedge clk);
    check("rst busy", 49'(busy), 49'(0));
    check("rst done", 49'(done), 49'(0));
    check("rst op_en", 49'(op_en), 49'(0));
    check("rst dist_we", 49'(dist_we), 49'(0));
    check("rst stale", 49'(stale), 49'(0));
    check("rst overflow", 49'(overflow), 49'(0));
    check("rst dist_addr", 49'(dist_addr), 49'(0));
    check("rst adj_addr", 49'(adj_addr), 49'(0));
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run(tbl[i]);
    check("mem dist1", 49'(dist_mem[1]), 49'(16'd4));
    check("mem dist2", 49'(dist_mem[2]), 49'(16'd7));
    check("mem dist5", 49'(dist_mem[5]), 49'(16'hFFFF));
    check("mem dist7", 49'(dist_mem[7]), 49'(16'hFFFF));
    check("mem dist14", 49'(dist_mem[14]), 49'(16'd6));
    pop_vertex = 16'd15;
    pop_dist = 16'd0;
    queue_length = 16'd0;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!op_en && cyc < 100);
    check("v15 push_cycle", 49'(cyc), 49'(9));
    @(negedge clk);
    check("v15 busy_in_wait", 49'(busy), 49'(1));
    check("v15 op_en_in_wait", 49'(op_en), 49'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid busy", 49'(busy), 49'(0));
    check("rst_mid op_en", 49'(op_en), 49'(0));
    check("rst_mid overflow", 49'(overflow), 49'(0));
    reset = 1'b0;
    r = '{v:16'd0, pd:16'd0, ql:16'd0, dc:13, np:0, st:1'b0, ov:1'b0, dbl:1'b0, fp:'0, lp:'0};
    run(r);
    check("mem dist16", 49'(dist_mem[16]), 49'(16'd1));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
